// File: rtl/spi_fifo_pkg.sv
// Shared constants and helpers for the SPI stream FIFO.
// Contents: default payload width/depth, read-pacing counter width,
//           and a power-of-two check used at elaboration.
package spi_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned GAP_CNT_W  = 8;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// Storage array for the SPI stream FIFO: DEPTH x DATA_W registers,
// one synchronous write port and one asynchronous read port, no reset.
// Ports:
//   i_clk      clock
//   i_wr_en    write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  read data (combinational)
module spi_fifo_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Asynchronous read port.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through stream FIFO between the APB register
// block and the SPI shift engine, with occupancy level, almost-full/empty
// flags, synchronous flush and a programmable read-pacing gap.
// Optional build macro: SPI_FIFO_OVF_FLAG_EN enables the sticky overflow
// flag ovf_o (cleared by err_clr_i); otherwise ovf_o is tied low.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   data_i/data_vld_i/data_rdy_o   write side
//   data_o/data_vld_o/data_rdy_i   read side
//   level_o, almost_full_o, almost_empty_o, ovf_o, err_clr_i
module spi_sync_fifo
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned AFULL_THR  = DEPTH - 1,
    parameter int unsigned AEMPTY_THR = 1,
    parameter int unsigned RD_GAP     = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_vld_i,
    output logic              data_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_vld_o,
    input  logic              data_rdy_i,
    output logic [ADDR_W:0]   level_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ovf_o,
    input  logic              err_clr_i
);

    localparam int unsigned    LVL_W     = ADDR_W + 1;
    localparam logic [LVL_W-1:0] LP_AFULL  = LVL_W'(AFULL_THR);
    localparam logic [LVL_W-1:0] LP_AEMPTY = LVL_W'(AEMPTY_THR);
    localparam logic [GAP_CNT_W-1:0] LP_GAP = GAP_CNT_W'(RD_GAP);

    // Elaboration-time parameter checks.
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
        $fatal(1, "spi_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_chk_addr
        $fatal(1, "spi_sync_fifo: ADDR_W must equal clog2(DEPTH)");
    end
    if (AFULL_THR > DEPTH) begin : g_chk_afull
        $fatal(1, "spi_sync_fifo: AFULL_THR exceeds DEPTH");
    end
    if (RD_GAP > 255) begin : g_chk_gap
        $fatal(1, "spi_sync_fifo: RD_GAP exceeds 255");
    end

    logic [LVL_W-1:0]     r_wr_ptr;
    logic [LVL_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [GAP_CNT_W-1:0] r_gap_cnt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    assign data_rdy_o = !w_full && !rst_i;
    assign data_vld_o = !w_empty && (r_gap_cnt == '0);

    // Flush and reset drop any same-cycle transfer, including the array write.
    assign w_push = data_vld_i && data_rdy_o && !flush_i;
    assign w_pop  = data_vld_o && data_rdy_i && !flush_i && !rst_i;

    // Pointer, level and pacing state.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LVL_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LVL_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_pop) begin
                r_gap_cnt <= LP_GAP;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
            end
        end
    end

    assign level_o        = r_level;
    assign almost_full_o  = (r_level >= LP_AFULL);
    assign almost_empty_o = (r_level <= LP_AEMPTY);

`ifdef SPI_FIFO_OVF_FLAG_EN
    logic r_ovf;

    // Sticky overflow: a write attempt while full sets it; set beats clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (data_vld_i && w_full) begin
            r_ovf <= 1'b1;
        end else if (err_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf_o = r_ovf;
`else
    logic w_unused_err_clr;

    assign ovf_o            = 1'b0;
    assign w_unused_err_clr = err_clr_i;
`endif

    spi_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (clk_i),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (data_i),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (data_o)
    );

endmodule
